acq_sequencer: RTL

//  Chip-level acquisition controller that sequences all channel state machines.

---
 rtl/acq_sequencer_pkg.sv | 64 ++++++
 rtl/acq_sequencer_sync_2ff.sv | 26 ++
 rtl/acq_sequencer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/acq_sequencer_pkg.sv
// Shared types for the acquisition sequencer.
// States, host command codes, sampling modes and count helpers.
package acq_sequencer_pkg;

    typedef enum logic [3:0] {
        SEQ_IDLE,
        SEQ_P_START,
        SEQ_P_MODE,
        SEQ_ACQUIRE,
        SEQ_DELAY,
        SEQ_P_STOP,
        SEQ_STOPPED,
        SEQ_P_RD,
        SEQ_READOUT,
        SEQ_DONE
    } seq_state_t;

    typedef enum logic [1:0] {
        CMD_ARM     = 2'd0,
        CMD_STOP    = 2'd1,
        CMD_READOUT = 2'd2,
        CMD_ABORT   = 2'd3
    } cmd_op_t;

    typedef enum logic [1:0] {
        MODE_SAMPLE1 = 2'd0,
        MODE_SAMPLE2 = 2'd1,
        MODE_SAMPLE4 = 2'd2
    } mode_t;

    localparam int I_START  = 0;
    localparam int I_S1     = 1;
    localparam int I_S2     = 2;
    localparam int I_S4     = 3;
    localparam int I_STOP   = 4;
    localparam int I_RD     = 5;
    localparam int NUM_INST = 6;

    function automatic logic [2:0] maxcnt(input mode_t m);
        logic [2:0] r;
        unique case (m)
            MODE_SAMPLE1: r = 3'd4;
            MODE_SAMPLE2: r = 3'd2;
            default:      r = 3'd1;
        endcase
        return r;
    endfunction

    // Saturate a raw channel count at 4, then clip to the mode limit.
    function automatic logic [2:0] clip_cnt(input logic [2:0] raw,
                                            input mode_t m);
        logic [2:0] sat;
        logic [2:0] lim;
        sat = (raw > 3'd4) ? 3'd4 : raw;
        lim = maxcnt(m);
        return (sat < lim) ? sat : lim;
    endfunction

    function automatic logic is_pulse(input seq_state_t s);
        return (s == SEQ_P_START) || (s == SEQ_P_MODE) ||
               (s == SEQ_P_STOP)  || (s == SEQ_P_RD);
    endfunction

endpackage

// File: rtl/acq_sequencer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Used for the OR'd channel stop request.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Shift the async level through two flops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/acq_sequencer.sv
// Chip-level acquisition sequencer: host commands to channel
// instruction pulses, post-trigger stop and (channel, buffer) readout walk.
module acq_sequencer
    import acq_sequencer_pkg::*;
#(
    parameter int NUM_CH     = 8,
    parameter int STOP_DLY_W = 8,
    parameter int PULSE_LEN  = 2
) (
    input  logic                      CLK,
    input  logic                      RSTB,
    input  logic                      cmd_valid,
    input  logic [1:0]                cmd_op,
    input  logic [1:0]                cmd_mode,
    input  logic                      auto_stop_en,
    input  logic [STOP_DLY_W-1:0]     stop_delay,
    output logic                      cmd_ready,
    output logic                      cmd_err,
    input  logic                      STOP_REQUEST,
    input  logic [3*NUM_CH-1:0]       trigger_cnt_in,
    output logic                      INST_START,
    output logic                      start1,
    output logic                      start2,
    output logic                      start4,
    output logic                      INST_STOP,
    output logic                      INST_READOUT,
    output logic                      ro_valid,
    output logic [$clog2(NUM_CH)-1:0] ro_ch,
    output logic [2:0]                ro_buf,
    input  logic                      ro_ready,
    output logic                      busy,
    output logic                      done
);

    localparam int CHW = $clog2(NUM_CH);
    localparam int PW  = $clog2(PULSE_LEN + 2);
    localparam logic [PW-1:0] PLEN = PW'(PULSE_LEN);

    seq_state_t              state_q, state_d;
    mode_t                   mode_q, mode_d;
    logic [STOP_DLY_W-1:0]   sdly_q, sdly_d;
    logic [STOP_DLY_W-1:0]   dly_q, dly_d;
    logic [PW-1:0]           pcnt_q, pcnt_d;
    logic                    abort_q, abort_d;
    logic                    cmd_err_q, cmd_err_d;
    logic                    stop_prev_q;
    logic [NUM_INST-1:0]     inst_q, inst_d;
    logic [2:0]              cnt_q [NUM_CH];
    logic [2:0]              cnt_d [NUM_CH];
    logic [CHW-1:0]          ro_ch_q, ro_ch_d;
    logic [2:0]              ro_buf_q, ro_buf_d;

    logic                    stop_s;
    logic                    stop_rise;
    logic                    cmd_acc;
    cmd_op_t                 op;
    logic [2:0]              n_in [NUM_CH];
    logic                    first_found;
    logic [CHW-1:0]          first_ch;
    logic                    next_found;
    logic [CHW-1:0]          next_ch;
    logic                    pon;

    sync_2ff u_sync_stop (
        .clk_i  (CLK),
        .rst_ni (RSTB),
        .d_i    (STOP_REQUEST),
        .q_o    (stop_s)
    );

    // Only a fresh rising edge ends acquisition; a stale high level never does.
    assign stop_rise = stop_s & ~stop_prev_q;
    assign cmd_ready = state_q inside {SEQ_IDLE, SEQ_ACQUIRE,
                                       SEQ_DELAY, SEQ_STOPPED};
    assign cmd_acc   = cmd_valid & cmd_ready;
    assign op        = cmd_op_t'(cmd_op);

    // Per-channel buffer counts as they would be sampled now.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            n_in[i] = clip_cnt(trigger_cnt_in[3*i +: 3], mode_q);
        end
    end

    // Lowest channel with data, searched from the live counts.
    always_comb begin
        first_found = 1'b0;
        first_ch    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (n_in[i] != 3'd0) begin
                first_found = 1'b1;
                first_ch    = CHW'(i);
            end
        end
    end

    // Next channel with data above the one being read.
    always_comb begin
        next_found = 1'b0;
        next_ch    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (i > int'(ro_ch_q) && cnt_q[i] != 3'd0) begin
                next_found = 1'b1;
                next_ch    = CHW'(i);
            end
        end
    end

    // Sequencer next-state and datapath updates.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        sdly_d    = sdly_q;
        dly_d     = dly_q;
        abort_d   = abort_q;
        cnt_d     = cnt_q;
        ro_ch_d   = ro_ch_q;
        ro_buf_d  = ro_buf_q;
        cmd_err_d = 1'b0;
        unique case (state_q)
            SEQ_IDLE: begin
                if (cmd_acc) begin
                    if (op == CMD_ARM) begin
                        state_d = SEQ_P_START;
                        mode_d  = mode_t'(cmd_mode);
                        sdly_d  = stop_delay;
                        abort_d = 1'b0;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end
            SEQ_P_START: begin
                if (pcnt_q == PLEN) state_d = SEQ_P_MODE;
            end
            SEQ_P_MODE: begin
                if (pcnt_q == PLEN) state_d = SEQ_ACQUIRE;
            end
            SEQ_ACQUIRE, SEQ_DELAY: begin
                if (cmd_acc) begin
                    if (op == CMD_STOP) begin
                        state_d = SEQ_P_STOP;
                    end else if (op == CMD_ABORT) begin
                        state_d = SEQ_P_STOP;
                        abort_d = 1'b1;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end else if (state_q == SEQ_ACQUIRE) begin
                    if (stop_rise && auto_stop_en) begin
                        state_d = SEQ_DELAY;
                        dly_d   = sdly_q;
                    end
                end else if (dly_q == '0) begin
                    state_d = SEQ_P_STOP;
                end else begin
                    dly_d = dly_q - 1'b1;
                end
            end
            SEQ_P_STOP: begin
                if (pcnt_q == PLEN) begin
                    state_d = abort_q ? SEQ_IDLE : SEQ_STOPPED;
                end
            end
            SEQ_STOPPED: begin
                if (cmd_acc) begin
                    if (op == CMD_READOUT) begin
                        state_d = SEQ_P_RD;
                    end else if (op == CMD_ABORT) begin
                        state_d = SEQ_IDLE;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end
            SEQ_P_RD: begin
                if (pcnt_q == PLEN) begin
                    cnt_d    = n_in;
                    ro_ch_d  = first_ch;
                    ro_buf_d = 3'd0;
                    state_d  = first_found ? SEQ_READOUT : SEQ_DONE;
                end
            end
            SEQ_READOUT: begin
                if (ro_ready) begin
                    if ((ro_buf_q + 3'd1) < cnt_q[ro_ch_q]) begin
                        ro_buf_d = ro_buf_q + 3'd1;
                    end else if (next_found) begin
                        ro_ch_d  = next_ch;
                        ro_buf_d = 3'd0;
                    end else begin
                        state_d = SEQ_DONE;
                    end
                end
            end
            SEQ_DONE: begin
                state_d = SEQ_IDLE;
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
    end

    // Pulse states hold PULSE_LEN high cycles plus one trailing low cycle.
    always_comb begin
        pcnt_d = '0;
        if (state_d == state_q && is_pulse(state_q)) begin
            pcnt_d = pcnt_q + 1'b1;
        end
    end

    // Instruction levels for the next cycle, aligned with the state register.
    always_comb begin
        inst_d = '0;
        pon    = pcnt_d < PLEN;
        unique case (state_d)
            SEQ_P_START: inst_d[I_START] = pon;
            SEQ_P_MODE: begin
                unique case (mode_q)
                    MODE_SAMPLE1: inst_d[I_S1] = pon;
                    MODE_SAMPLE2: inst_d[I_S2] = pon;
                    default:      inst_d[I_S4] = pon;
                endcase
            end
            SEQ_P_STOP: inst_d[I_STOP] = pon;
            SEQ_P_RD:   inst_d[I_RD]   = pon;
            default: ;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q     <= SEQ_IDLE;
            mode_q      <= MODE_SAMPLE1;
            sdly_q      <= '0;
            dly_q       <= '0;
            pcnt_q      <= '0;
            abort_q     <= 1'b0;
            cmd_err_q   <= 1'b0;
            stop_prev_q <= 1'b0;
            inst_q      <= '0;
            ro_ch_q     <= '0;
            ro_buf_q    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            sdly_q      <= sdly_d;
            dly_q       <= dly_d;
            pcnt_q      <= pcnt_d;
            abort_q     <= abort_d;
            cmd_err_q   <= cmd_err_d;
            stop_prev_q <= stop_s;
            inst_q      <= inst_d;
            ro_ch_q     <= ro_ch_d;
            ro_buf_q    <= ro_buf_d;
            cnt_q       <= cnt_d;
        end
    end

    assign INST_START   = inst_q[I_START];
    assign start1       = inst_q[I_S1];
    assign start2       = inst_q[I_S2];
    assign start4       = inst_q[I_S4];
    assign INST_STOP    = inst_q[I_STOP];
    assign INST_READOUT = inst_q[I_RD];
    assign cmd_err      = cmd_err_q;
    assign ro_valid     = (state_q == SEQ_READOUT);
    assign ro_ch        = ro_ch_q;
    assign ro_buf       = ro_buf_q;
    assign busy         = (state_q != SEQ_IDLE);
    assign done         = (state_q == SEQ_DONE);

endmodule
